multizone_sprinkler_ctrl: RTL and testbench
===========================================

// Module: multizone_sprinkler_ctrl
// PURPOSE
//  Next-gen sprinkler controller: parses the GPS NMEA byte stream ($GPRMC UTC time) and waters
//  NUM_ZONES zones one at a time, once per dark period. Rain lockout is debounced.
//  Sits between the GPS UART byte output and the zone valve drivers.
//  Replaces the single-zone hw3_sprinkler.
// PARAMETERS
//  NUM_ZONES      4      number of zones; zone_active_out width
//  TICK_W         16     width of the per-zone duration counter
//  ZONE_TICKS     1000   clk cycles each zone stays on (1..2^TICK_W-1)
//  DARK_START_HR  23     UTC hour at which dark begins (0..23)
//  DARK_END_HR    11     UTC hour at which dark ends (0..23)
//  RAIN_DEBOUNCE  8      consecutive samples required to change lockout state
// PORTS
//  clk              in   1          system clock; all logic on posedge
//  rst              in   1          asynchronous, active-high reset
//  rain_sensor_in   in   1          1 = rain detected
//  gps_valid_in     in   1          gps_data_in holds a new byte this cycle
//  gps_data_in      in   8          ASCII byte from GPS UART
//  zone_active_out  out  NUM_ZONES  one-hot valve enable, or all zero
//  time_valid_out   out  1          at least one good $GPRMC time parsed since reset
//  utc_hour_out     out  5          last parsed UTC hour (0..23)
//  utc_min_out      out  6          last parsed UTC minute (0..59)
//  rain_lockout_out out  1          debounced rain state
// BEHAVIOUR
//  Reset: every output is 0. Parser is in HUNT. FSM is in IDLE. All counters are 0.
//  Parser samples a byte on a posedge where gps_valid_in=1; it ignores the byte otherwise.
//   - Match sequence: '$','G','P','R','M','C',',' then 4 ASCII digits H1 H0 M1 M0.
//   - '$' at any point restarts the match at position 1. Any other mismatch or non-digit
//     returns the parser to HUNT.
//   - hour = H1*10+H0 and min = M1*10+M0; width is 5 and 6 bits.
//     The value is discarded if hour>23 or min>59.
//   - On accept, utc_hour_out, utc_min_out and time_valid_out=1 update on the edge after
//     M0 is sampled (latency 1 clk). The remaining sentence bytes are ignored until the next '$'.
//  dark: requires time_valid_out=1.
//   - start>end:  hour>=START || hour<END
//   - start<end:  START<=hour<END
//   - start==end: never dark
//  Rain:
//   - rain_lockout_out sets after RAIN_DEBOUNCE consecutive cycles of rain_sensor_in=1.
//   - It clears after RAIN_DEBOUNCE consecutive cycles of rain_sensor_in=0.
//   - A shorter glitch has no effect.
//  FSM:
//   - IDLE:  go to RUN when dark && !lockout. idx=0, tick=0.
//   - RUN:   zone_active_out = 1<<idx. tick increments each cycle.
//            When tick==ZONE_TICKS-1: tick=0 and idx++.
//            After the last zone finishes, go to DONE.
//   - RUN:   lockout=1 goes to PAUSE. !dark goes to DONE (abort). Abort has priority.
//   - PAUSE: outputs 0. idx and tick are held.
//            Go to RUN when !lockout && dark; the zone resumes its remaining ticks.
//            Go to DONE when !dark.
//   - DONE:  outputs 0. Go to IDLE when !dark. This guarantees one cycle per dark period.
//  zone_active_out is registered and follows state/idx with 1 clk latency.
//  It is never more than one-hot.
//  Rst mid-operation: outputs clear asynchronously. The next run requires a fresh $GPRMC.
// TESTING
//  1. Default params, ZONE_TICKS=4.
//     Send "$GPRMC,0130"
//       -> hour=1, min=30, valid=1 one clk after '0'.
//       -> zones 0001,0010,0100,1000 for 4 clks each, then 0. FSM in DONE.
//  2. Send "$GPRMC,2599" after reset
//       -> time_valid_out stays 0 and zones stay 0.
//     Send "$GPGGA,0130"
//       -> ignored.
//     Send "$G$GPRMC,0130"
//       -> accepted with hour=1.
//  3. During zone 2, tick 1, hold rain=1 for 8 clks
//       -> lockout=1, zones=0.
//     Drop rain for 8 clks
//       -> zone 2 resumes for its remaining 3 ticks.
//     A 5-clk rain pulse
//       -> no change.
//  4. During RUN, send "$GPRMC,1200"
//       -> zones=0, DONE then IDLE, no restart.
//     Then send "$GPRMC,2300"
//       -> a new full run starts.
//  5. Assert rst mid-RUN
//       -> all outputs 0 immediately.
//     Release rst with no new sentence
//       -> stays IDLE.
//  6. Set DARK_START_HR=DARK_END_HR=5 and send any hour
//       -> never waters.

Source files
------------

// File: rtl/multizone_sprinkler_ctrl.sv
// multizone_sprinkler_ctrl
//   Parses $GPRMC UTC time out of a GPS NMEA byte stream and waters NUM_ZONES
//   zones one after another, once per dark period. A debounced rain sensor
//   pauses watering. The remaining ticks of the current zone resume once the
//   rain lockout clears.
// Ports
//   clk, rst           clock, asynchronous active-high reset
//   rain_sensor_in     raw rain sensor, 1 = rain
//   gps_valid_in       gps_data_in carries a new byte this cycle
//   gps_data_in        ASCII byte from the GPS UART
//   zone_active_out    one-hot valve enable (or all zero), registered
//   time_valid_out     a good $GPRMC time has been parsed since reset
//   utc_hour_out       last parsed UTC hour
//   utc_min_out        last parsed UTC minute
//   rain_lockout_out   debounced rain state
module multizone_sprinkler_ctrl #(
    parameter int NUM_ZONES     = 4,
    parameter int TICK_W        = 16,
    parameter int ZONE_TICKS    = 1000,
    parameter int DARK_START_HR = 23,
    parameter int DARK_END_HR   = 11,
    parameter int RAIN_DEBOUNCE = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rain_sensor_in,
    input  logic                 gps_valid_in,
    input  logic [7:0]           gps_data_in,
    output logic [NUM_ZONES-1:0] zone_active_out,
    output logic                 time_valid_out,
    output logic [4:0]           utc_hour_out,
    output logic [5:0]           utc_min_out,
    output logic                 rain_lockout_out
);
    localparam int IDX_W = (NUM_ZONES > 1) ? $clog2(NUM_ZONES) : 1;
    localparam int CNT_W = $clog2(RAIN_DEBOUNCE + 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(ZONE_TICKS - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_ZONES - 1);
    localparam logic [CNT_W-1:0]  DEB_LAST  = CNT_W'(RAIN_DEBOUNCE - 1);
    localparam logic [4:0]        START_H   = 5'(DARK_START_HR);
    localparam logic [4:0]        END_H     = 5'(DARK_END_HR);

    // ---------------- NMEA parser ----------------
    // pos = number of sentence bytes matched so far; 0 is HUNT.
    // 1..6 expect the rest of "$GPRMC,", 7..10 expect H1 H0 M1 M0.
    logic [3:0] pos;
    logic [3:0] h1, h0, m1;
    logic       acc_pend;
    logic [4:0] hour_pend;
    logic [5:0] min_pend;
    logic [6:0] hour_full, min_full;
    logic       is_digit;
    logic [3:0] dval;

    function automatic logic [7:0] hdr_char(input logic [3:0] p);
        case (p)
            4'd1:    hdr_char = 8'h47; // G
            4'd2:    hdr_char = 8'h50; // P
            4'd3:    hdr_char = 8'h52; // R
            4'd4:    hdr_char = 8'h4D; // M
            4'd5:    hdr_char = 8'h43; // C
            4'd6:    hdr_char = 8'h2C; // ,
            default: hdr_char = 8'h24; // $
        endcase
    endfunction

    assign is_digit  = (gps_data_in >= 8'h30) && (gps_data_in <= 8'h39);
    assign dval      = gps_data_in[3:0];
    assign hour_full = {3'b0, h1} * 7'd10 + {3'b0, h0};
    assign min_full  = {3'b0, m1} * 7'd10 + {3'b0, dval};

    // The accepted time is staged one cycle (acc_pend) so the visible outputs
    // change on the edge after M0 is sampled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos            <= '0;
            h1             <= '0;
            h0             <= '0;
            m1             <= '0;
            acc_pend       <= 1'b0;
            hour_pend      <= '0;
            min_pend       <= '0;
            time_valid_out <= 1'b0;
            utc_hour_out   <= '0;
            utc_min_out    <= '0;
        end else begin
            acc_pend <= 1'b0;
            if (acc_pend) begin
                time_valid_out <= 1'b1;
                utc_hour_out   <= hour_pend;
                utc_min_out    <= min_pend;
            end
            if (gps_valid_in) begin
                if (gps_data_in == 8'h24) begin
                    pos <= 4'd1;
                end else if (pos >= 4'd1 && pos <= 4'd6 && gps_data_in == hdr_char(pos)) begin
                    pos <= pos + 4'd1;
                end else if (pos >= 4'd7 && is_digit) begin
                    case (pos)
                        4'd7:    h1 <= dval;
                        4'd8:    h0 <= dval;
                        4'd9:    m1 <= dval;
                        default: ;
                    endcase
                    if (pos == 4'd10) begin
                        pos <= '0;
                        if (hour_full <= 7'd23 && min_full <= 7'd59) begin
                            acc_pend  <= 1'b1;
                            hour_pend <= hour_full[4:0];
                            min_pend  <= min_full[5:0];
                        end
                    end else begin
                        pos <= pos + 4'd1;
                    end
                end else begin
                    pos <= '0;
                end
            end
        end
    end

    // ---------------- dark window ----------------
    logic dark;
    always_comb begin
        dark = 1'b0;
        if (time_valid_out) begin
            if (START_H > END_H)
                dark = (utc_hour_out >= START_H) || (utc_hour_out < END_H);
            else if (START_H < END_H)
                dark = (utc_hour_out >= START_H) && (utc_hour_out < END_H);
        end
    end

    // ---------------- rain debounce ----------------
    // Counts consecutive samples disagreeing with the current lockout state.
    logic [CNT_W-1:0] rain_cnt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rain_cnt         <= '0;
            rain_lockout_out <= 1'b0;
        end else if (rain_sensor_in == rain_lockout_out) begin
            rain_cnt <= '0;
        end else if (rain_cnt == DEB_LAST) begin
            rain_cnt         <= '0;
            rain_lockout_out <= ~rain_lockout_out;
        end else begin
            rain_cnt <= rain_cnt + CNT_W'(1);
        end
    end

    // ---------------- zone sequencer ----------------
    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
    state_t            state, state_nx;
    logic [IDX_W-1:0]  idx, idx_nx;
    logic [TICK_W-1:0] tick, tick_nx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            idx             <= '0;
            tick            <= '0;
            zone_active_out <= '0;
        end else begin
            state           <= state_nx;
            idx             <= idx_nx;
            tick            <= tick_nx;
            zone_active_out <= (state == RUN) ? (NUM_ZONES'(1) << idx) : '0;
        end
    end

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        tick_nx  = tick;
        case (state)
            IDLE: begin
                idx_nx  = '0;
                tick_nx = '0;
                if (dark && !rain_lockout_out) state_nx = RUN;
            end
            RUN: begin
                // Leaving the dark window aborts ahead of a rain pause.
                if (!dark) begin
                    state_nx = DONE;
                end else if (rain_lockout_out) begin
                    state_nx = PAUSE;
                end else if (tick == TICK_LAST) begin
                    tick_nx = '0;
                    if (idx == IDX_LAST) state_nx = DONE;
                    else                 idx_nx   = idx + IDX_W'(1);
                end else begin
                    tick_nx = tick + TICK_W'(1);
                end
            end
            PAUSE: begin
                if (!dark)                  state_nx = DONE;
                else if (!rain_lockout_out) state_nx = RUN;
            end
            DONE: begin
                // Wait for the dark period to end so each period waters once.
                if (!dark) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end
endmodule

// File: tb/tb_multizone_sprinkler_ctrl.sv
// Bench for multizone_sprinkler_ctrl: directed scenarios plus randomized
// NMEA/rain traffic, checked every cycle against a sentence/progress level
// reference model. A second instance with START==END must never water.
module tb_multizone_sprinkler_ctrl;
    localparam int NZ  = 4;
    localparam int ZT  = 4;
    localparam int DS  = 23;
    localparam int DE  = 11;
    localparam int DEB = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rain_sensor_in = 1'b0;
    logic       gps_valid_in = 1'b0;
    logic [7:0] gps_data_in = 8'h00;
    logic [NZ-1:0] zone_active_out, zone_eq;
    logic       time_valid_out, tv_eq;
    logic [4:0] utc_hour_out, hr_eq;
    logic [5:0] utc_min_out, mn_eq;
    logic       rain_lockout_out, lk_eq;

    always #5 clk = ~clk;

    multizone_sprinkler_ctrl #(.NUM_ZONES(NZ), .TICK_W(16), .ZONE_TICKS(ZT),
        .DARK_START_HR(DS), .DARK_END_HR(DE), .RAIN_DEBOUNCE(DEB)) u_dut (
        .clk(clk), .rst(rst), .rain_sensor_in(rain_sensor_in),
        .gps_valid_in(gps_valid_in), .gps_data_in(gps_data_in),
        .zone_active_out(zone_active_out), .time_valid_out(time_valid_out),
        .utc_hour_out(utc_hour_out), .utc_min_out(utc_min_out),
        .rain_lockout_out(rain_lockout_out));

    multizone_sprinkler_ctrl #(.NUM_ZONES(NZ), .TICK_W(16), .ZONE_TICKS(ZT),
        .DARK_START_HR(5), .DARK_END_HR(5), .RAIN_DEBOUNCE(DEB)) u_dut_eq (
        .clk(clk), .rst(rst), .rain_sensor_in(rain_sensor_in),
        .gps_valid_in(gps_valid_in), .gps_data_in(gps_data_in),
        .zone_active_out(zone_eq), .time_valid_out(tv_eq),
        .utc_hour_out(hr_eq), .utc_min_out(mn_eq),
        .rain_lockout_out(lk_eq));

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    // ---------------- reference model ----------------
    // Time: a sentence buffer started by '$', judged when 11 bytes are in.
    // Watering: progress = run cycles consumed; zone = progress / ZT.
    bit        m_valid, m_pend, m_lock, m_run, m_paused, m_fin, m_rv;
    int        m_hour, m_min, m_ph, m_pm, m_prog, m_rl, m_len;
    byte       m_buf[11];
    logic [NZ-1:0] m_zone;
    string     m_hdr = "$GPRMC,";

    function automatic bit m_dark(bit v, int h, int s, int e);
        if (!v) return 1'b0;
        if (s > e) return (h >= s) || (h < e);
        if (s < e) return (h >= s) && (h < e);
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_pend = 0; m_lock = 0; m_run = 0; m_paused = 0; m_fin = 0;
        m_rv = 0; m_hour = 0; m_min = 0; m_ph = 0; m_pm = 0; m_prog = 0;
        m_rl = 0; m_len = 0; m_zone = '0;
    endtask

    task automatic model_step(input bit rain, input bit gv, input logic [7:0] gd);
        bit d, lk, ok;
        int h, mn;
        d  = m_dark(m_valid, m_hour, DS, DE);
        lk = m_lock;
        m_zone = m_run ? (NZ'(1) << (m_prog / ZT)) : '0;
        if (m_fin) begin
            if (!d) m_fin = 0;
        end else if (m_run) begin
            if (!d)      begin m_run = 0; m_fin = 1; end
            else if (lk) begin m_run = 0; m_paused = 1; end
            else begin
                m_prog++;
                if (m_prog == NZ * ZT) begin m_run = 0; m_fin = 1; end
            end
        end else if (m_paused) begin
            if (!d)       begin m_paused = 0; m_fin = 1; end
            else if (!lk) begin m_paused = 0; m_run = 1; end
        end else begin
            m_prog = 0;
            if (d && !lk) m_run = 1;
        end
        if (m_pend) begin m_valid = 1; m_hour = m_ph; m_min = m_pm; end
        m_pend = 0;
        if (gv) begin
            if (gd == 8'h24) begin
                m_buf[0] = gd; m_len = 1;
            end else if (m_len > 0) begin
                m_buf[m_len] = gd; m_len++;
                if (m_len == 11) begin
                    ok = 1;
                    for (int i = 0; i < 7; i++) if (m_buf[i] != m_hdr[i]) ok = 0;
                    for (int i = 7; i < 11; i++) if (m_buf[i] < 8'h30 || m_buf[i] > 8'h39) ok = 0;
                    if (ok) begin
                        h  = (m_buf[7] - 48) * 10 + (m_buf[8] - 48);
                        mn = (m_buf[9] - 48) * 10 + (m_buf[10] - 48);
                        if (h <= 23 && mn <= 59) begin m_pend = 1; m_ph = h; m_pm = mn; end
                    end
                    m_len = 0;
                end
            end
        end
        if (rain == m_rv) m_rl++;
        else begin m_rv = rain; m_rl = 1; end
        if (m_rl >= DEB && m_rv != m_lock) m_lock = m_rv;
    endtask

    always @(posedge clk) begin
        if (rst) model_reset();
        else model_step(rain_sensor_in, gps_valid_in, gps_data_in);
        #1;
        chk("zone", 32'(zone_active_out), 32'(m_zone));
        chk("tvalid", 32'(time_valid_out), 32'(m_valid));
        chk("hour", 32'(utc_hour_out), 32'(m_hour));
        chk("min", 32'(utc_min_out), 32'(m_min));
        chk("lockout", 32'(rain_lockout_out), 32'(m_lock));
        chk("eq_zone", 32'(zone_eq), 32'd0);
        chk("eq_tvalid", 32'(tv_eq), 32'(m_valid));
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            gps_valid_in = 1'b0;
            gps_data_in  = 8'($urandom);
        end
    endtask

    task automatic send_str(input string s, input int max_gap);
        for (int i = 0; i < s.len(); i++) begin
            @(negedge clk);
            gps_valid_in = 1'b1;
            gps_data_in  = s[i];
            if (max_gap > 0) idle($urandom_range(0, max_gap));
        end
        @(negedge clk);
        gps_valid_in = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        rain_sensor_in = 1'b0;
        gps_valid_in   = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_zone(input logic [NZ-1:0] z, input string tag);
        int n;
        n = 0;
        while (zone_active_out !== z && n < 100) begin @(negedge clk); n++; end
        chk(tag, 32'(zone_active_out), 32'(z));
    endtask

    string   sent;
    bit      rand_done;
    int      hh, mm;
    int      hours[7] = '{23, 0, 1, 5, 10, 11, 12};

    initial begin
        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_zone", 32'(zone_active_out), 32'd0);
        chk("rst_tvalid", 32'(time_valid_out), 32'd0);
        chk("rst_hour", 32'(utc_hour_out), 32'd0);
        chk("rst_lock", 32'(rain_lockout_out), 32'd0);
        rst = 1'b0;

        // 1: basic sentence, latency and full run
        send_str("$GPRMC,0130", 0);
        chk("lat_m0", 32'(time_valid_out), 32'd0);
        @(negedge clk);
        chk("lat_p1", 32'(time_valid_out), 32'd1);
        chk("hour_01", 32'(utc_hour_out), 32'd1);
        chk("min_30", 32'(utc_min_out), 32'd30);
        wait_zone(4'b0001, "run_z0");
        repeat (ZT) @(negedge clk);
        chk("run_z1", 32'(zone_active_out), 32'b0010);
        repeat (ZT) @(negedge clk);
        chk("run_z2", 32'(zone_active_out), 32'b0100);
        repeat (ZT) @(negedge clk);
        chk("run_z3", 32'(zone_active_out), 32'b1000);
        repeat (ZT + 20) @(negedge clk);
        chk("run_once", 32'(zone_active_out), 32'd0);

        // 2: rejected sentences, then '$' restart
        do_reset();
        send_str("$GPRMC,2599", 0);
        send_str("$GPGGA,0130", 1);
        idle(20);
        chk("bad_tvalid", 32'(time_valid_out), 32'd0);
        chk("bad_zone", 32'(zone_active_out), 32'd0);
        send_str("$G$GPRMC,0130", 2);
        idle(2);
        chk("restart_valid", 32'(time_valid_out), 32'd1);
        chk("restart_hour", 32'(utc_hour_out), 32'd1);

        // 3: rain pause / resume, short glitch
        do_reset();
        send_str("$GPRMC,0130", 0);
        wait_zone(4'b0001, "rain_z0");
        repeat (2) @(negedge clk);
        rain_sensor_in = 1'b1;
        repeat (DEB + 2) @(negedge clk);
        chk("rain_lock", 32'(rain_lockout_out), 32'd1);
        chk("rain_off", 32'(zone_active_out), 32'd0);
        rain_sensor_in = 1'b0;
        repeat (DEB + 2) @(negedge clk);
        chk("rain_clear", 32'(rain_lockout_out), 32'd0);
        chk("rain_resume", 32'(zone_active_out != 0), 32'd1);
        rain_sensor_in = 1'b1;
        repeat (5) @(negedge clk);
        rain_sensor_in = 1'b0;
        repeat (3) @(negedge clk);
        chk("glitch", 32'(rain_lockout_out), 32'd0);
        idle(30);

        // 4: daylight abort, then a new dark period
        do_reset();
        send_str("$GPRMC,0130", 0);
        wait_zone(4'b0001, "abort_z0");
        send_str("$GPRMC,1200", 0);
        repeat (3) @(negedge clk);
        chk("abort_off", 32'(zone_active_out), 32'd0);
        idle(30);
        chk("abort_stay", 32'(zone_active_out), 32'd0);
        send_str("$GPRMC,2300", 0);
        repeat (4) @(negedge clk);
        chk("new_run", 32'(zone_active_out), 32'b0001);
        idle(30);

        // 5: reset in the middle of a run
        do_reset();
        send_str("$GPRMC,0130", 0);
        wait_zone(4'b0001, "mid_z0");
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("async_zone", 32'(zone_active_out), 32'd0);
        chk("async_tvalid", 32'(time_valid_out), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        idle(30);
        chk("post_rst", 32'(zone_active_out), 32'd0);

        // Randomized traffic: sentences and rain bursts in parallel
        rand_done = 0;
        fork
            begin
                for (int k = 0; k < 60; k++) begin
                    hh = ($urandom_range(0, 1) == 0) ? hours[$urandom_range(0, 6)]
                                                     : int'($urandom_range(0, 29));
                    mm = $urandom_range(0, 69);
                    case ($urandom_range(0, 7))
                        0:       sent = $sformatf("$GPGGA,%02d%02d", hh, mm);
                        1:       sent = $sformatf("$GPRMC,%02dA%02d", hh, mm);
                        2:       sent = $sformatf("$GP$GPRMC,%02d%02d", hh, mm);
                        default: sent = $sformatf("$GPRMC,%02d%02d", hh, mm);
                    endcase
                    sent = {sent, ",A,48*1F"};
                    send_str(sent, $urandom_range(0, 2));
                    idle($urandom_range(0, 40));
                end
                rand_done = 1;
            end
            begin
                while (!rand_done) begin
                    @(negedge clk);
                    rain_sensor_in = ($urandom_range(0, 2) == 0);
                    repeat ($urandom_range(1, 14)) begin
                        if (!rand_done) @(negedge clk);
                    end
                end
            end
        join
        rain_sensor_in = 1'b0;
        idle(20);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
